audio_capture: RTL and testbench

- Record path: the capture-side counterpart of the ROM playback path.
- Pops stereo samples from the audio_codec ADC side (read_ready/read handshake), mixes them to mono and writes them sequentially into an external single-port sample RAM (same layout as audio_rom: 24-bit words, 14-bit address).
- Sits between audio_codec and the recording RAM.
- Controlled by start/stop strobes from the KEY/SW debounce logic.

---
 rtl/audio_capture.sv | 159 +++++++++++++++
 tb/tb_audio_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_capture.sv
`default_nettype none
// =============================================================================
// audio_capture : pops stereo codec ADC samples, mixes them to mono and writes
//                 them sequentially into the recording RAM. Optional feature
//                 macro AUDIO_CAPTURE_PEAK_EN tracks the peak |mono| written.
// Revision      : 1.0
// =============================================================================
module audio_capture #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16384,
    parameter int SKIP   = 0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sample_count,
    output logic [DATA_W-2:0] peak
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SKIP = 2'd1;
    localparam logic [1:0] S_REC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W  = ADDR_W + 1;
    localparam int PK_W   = DATA_W - 1;
    localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;

    logic [1:0]               r_state;
    logic [1:0]               w_next;
    logic [SKIP_W-1:0]        r_skip_cnt;
    logic                     w_active;
    logic                     w_begin;
    logic                     w_pop;
    logic                     w_write;
    logic                     w_skip_last;
    logic                     w_full_last;
    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W-1:0] w_mono;

    assign w_active    = (r_state == S_SKIP) || (r_state == S_REC);
    assign w_begin     = start && !stop && ((r_state == S_IDLE) || (r_state == S_DONE));
    // The !read term enforces the two-cycle minimum pop spacing.
    assign w_pop       = w_active && read_ready && !read && !stop;
    assign w_write     = w_pop && (r_state == S_REC);
    assign w_skip_last = (r_skip_cnt == SKIP_W'(SKIP - 1));
    assign w_full_last = (sample_count == CNT_W'(DEPTH - 1));

    // One extra bit of headroom so the sum never overflows before halving.
    assign w_sum  = {readdata_left[DATA_W-1], readdata_left}
                  + {readdata_right[DATA_W-1], readdata_right};
    assign w_mono = DATA_W'(w_sum >>> 1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_begin) w_next = (SKIP > 0) ? S_SKIP : S_REC;
            end
            S_SKIP: begin
                if (stop)                    w_next = S_IDLE;
                else if (w_pop && w_skip_last) w_next = S_REC;
            end
            S_REC: begin
                if (stop)                    w_next = S_IDLE;
                else if (w_pop && w_full_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (stop)         w_next = S_IDLE;
                else if (w_begin) w_next = (SKIP > 0) ? S_SKIP : S_REC;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SKIP:  busy = 1'b1;
            S_REC:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // sample_count doubles as the write pointer; it stops at DEPTH, never wraps.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            read         <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            sample_count <= '0;
            r_skip_cnt   <= '0;
        end else begin
            read   <= w_pop;
            ram_we <= w_write;
            if (w_begin) begin
                sample_count <= '0;
                r_skip_cnt   <= '0;
            end
            if (w_pop && (r_state == S_SKIP)) begin
                r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
            end
            if (w_write) begin
                ram_addr     <= sample_count[ADDR_W-1:0];
                ram_wdata    <= w_mono;
                sample_count <= sample_count + CNT_W'(1);
            end
        end
    end

`ifdef AUDIO_CAPTURE_PEAK_EN
    logic [PK_W-1:0] w_abs;

    // The most negative sample has no positive twin, so it saturates.
    always_comb begin
        w_abs = w_mono[PK_W-1:0];
        if (w_mono[DATA_W-1]) begin
            if (w_mono == {1'b1, {PK_W{1'b0}}}) w_abs = '1;
            else                                w_abs = PK_W'(-w_mono);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            peak <= '0;
        end else if (w_begin) begin
            peak <= '0;
        end else if (w_write && (w_abs > peak)) begin
            peak <= w_abs;
        end
    end
`else
    assign peak = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_capture.sv
`default_nettype none
// Testbench for audio_capture: three instances with different SKIP/DEPTH
// share one stimulus bus; each scenario checks the instance it targets.
module tb_audio_capture;
    localparam int DW = 24;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          read_ready = 1'b0;
    logic [DW-1:0] left = '0;
    logic [DW-1:0] right = '0;

    logic a_read, a_we, a_busy, a_done;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [AW:0]   a_cnt;
    logic [DW-2:0] a_peak;

    logic b_read, b_we, b_busy, b_done;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [AW:0]   b_cnt;
    logic [DW-2:0] b_peak;

    logic c_read, c_we, c_busy, c_done;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [AW:0]   c_cnt;
    logic [DW-2:0] c_peak;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_capture #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .SKIP(0)) u_a (
        .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop),
        .read_ready(read_ready), .readdata_left(left), .readdata_right(right),
        .read(a_read), .ram_addr(a_addr), .ram_wdata(a_wdata), .ram_we(a_we),
        .busy(a_busy), .done(a_done), .sample_count(a_cnt), .peak(a_peak));

    audio_capture #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(3), .SKIP(2)) u_b (
        .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop),
        .read_ready(read_ready), .readdata_left(left), .readdata_right(right),
        .read(b_read), .ram_addr(b_addr), .ram_wdata(b_wdata), .ram_we(b_we),
        .busy(b_busy), .done(b_done), .sample_count(b_cnt), .peak(b_peak));

    audio_capture #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(8), .SKIP(0)) u_c (
        .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop),
        .read_ready(read_ready), .readdata_left(left), .readdata_right(right),
        .read(c_read), .ram_addr(c_addr), .ram_wdata(c_wdata), .ram_we(c_we),
        .busy(c_busy), .done(c_done), .sample_count(c_cnt), .peak(c_peak));

    function automatic logic [DW-2:0] pk(input logic [DW-2:0] v);
`ifdef AUDIO_CAPTURE_PEAK_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; stop = 1'b0; read_ready = 1'b0;
        left = '0; right = '0;
        step; step;
        reset = 1'b0;
        step;
    endtask

    task automatic test_reset;
        logic [88:0] all_c;
        step;
        all_c = {c_read, c_we, c_busy, c_done, c_addr, c_wdata, c_cnt, c_peak};
        checks++;
        if (all_c !== '0) begin
            errors++; $display("FAIL reset_state: got %0h expected 0", all_c);
        end
        reset = 1'b0;
        step;
        start = 1'b1; step; start = 1'b0;
        read_ready = 1'b1; left = 24'd5; right = 24'd7;
        step;
        checks++;
        if (c_we !== 1'b1) begin
            errors++; $display("FAIL reset_pre_we: got %0b expected 1", c_we);
        end
        reset = 1'b1;
        #1;
        all_c = {c_read, c_we, c_busy, c_done, c_addr, c_wdata, c_cnt, c_peak};
        checks++;
        if (all_c !== '0) begin
            errors++; $display("FAIL reset_async: got %0h expected 0", all_c);
        end
        step;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if ({c_read, c_busy} !== 2'b00) begin
                errors++; $display("FAIL reset_idle_no_read: got %0b expected 00", {c_read, c_busy});
            end
        end
        read_ready = 1'b0;
    endtask

    task automatic test_record_basic;
        logic exp_pop;
        do_reset;
        left = 24'd100; right = 24'd300;
        start = 1'b1; step; start = 1'b0;
        read_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step;
            exp_pop = (i % 2 == 0) && (i < 8);
            checks++;
            if ({a_read, a_we} !== {exp_pop, exp_pop}) begin
                errors++; $display("FAIL basic_pop[%0d]: got read/we %0b expected %0b", i, {a_read, a_we}, {exp_pop, exp_pop});
            end
            if (exp_pop) begin
                checks++;
                if (a_addr !== AW'(i / 2) || a_wdata !== 24'd200) begin
                    errors++; $display("FAIL basic_write[%0d]: got addr %0d data %0d expected addr %0d data 200", i, a_addr, a_wdata, i / 2);
                end
            end
            checks++;
            if (a_done !== (i >= 6)) begin
                errors++; $display("FAIL basic_done[%0d]: got %0b expected %0b", i, a_done, (i >= 6));
            end
        end
        checks++;
        if (a_cnt !== 15'd4 || a_busy !== 1'b0) begin
            errors++; $display("FAIL basic_final: got count %0d busy %0b expected 4 0", a_cnt, a_busy);
        end
        start = 1'b1; step; start = 1'b0;
        checks++;
        if ({a_done, a_busy} !== 2'b01 || a_cnt !== 15'd0) begin
            errors++; $display("FAIL restart_from_done: got done/busy %0b count %0d expected 01 0", {a_done, a_busy}, a_cnt);
        end
        step;
        checks++;
        if (a_we !== 1'b1 || a_addr !== 14'd0) begin
            errors++; $display("FAIL restart_write: got we %0b addr %0d expected 1 0", a_we, a_addr);
        end
        read_ready = 1'b0;
    endtask

    task automatic test_skip;
        logic exp_read, exp_we;
        do_reset;
        left = 24'd100; right = 24'd300;
        start = 1'b1; step; start = 1'b0;
        read_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step;
            exp_read = (i % 2 == 0) && (i < 10);
            exp_we   = exp_read && (i >= 4);
            checks++;
            if ({b_read, b_we} !== {exp_read, exp_we}) begin
                errors++; $display("FAIL skip_pop[%0d]: got read/we %0b expected %0b", i, {b_read, b_we}, {exp_read, exp_we});
            end
            if (exp_we) begin
                checks++;
                if (b_addr !== AW'((i - 4) / 2)) begin
                    errors++; $display("FAIL skip_addr[%0d]: got %0d expected %0d", i, b_addr, (i - 4) / 2);
                end
            end
        end
        checks++;
        if (b_cnt !== 15'd3 || b_done !== 1'b1) begin
            errors++; $display("FAIL skip_final: got count %0d done %0b expected 3 1", b_cnt, b_done);
        end
        read_ready = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] l, input logic [DW-1:0] r,
                        input logic [DW-1:0] exp_w, input logic [DW-2:0] exp_pk,
                        input int exp_addr);
        left = l; right = r; read_ready = 1'b1;
        step;
        checks++;
        if (c_we !== 1'b1 || c_wdata !== exp_w || c_addr !== AW'(exp_addr)) begin
            errors++; $display("FAIL feed_write: got we %0b data %0h addr %0d expected 1 %0h %0d", c_we, c_wdata, c_addr, exp_w, exp_addr);
        end
        read_ready = 1'b0;
        step;
        checks++;
        if (c_peak !== pk(exp_pk)) begin
            errors++; $display("FAIL feed_peak: got %0h expected %0h", c_peak, pk(exp_pk));
        end
    endtask

    task automatic test_data_peak_stop;
        do_reset;
        start = 1'b1; step; start = 1'b0;
        feed(24'd10, 24'd10, 24'd10, 23'd10, 0);
        feed(-24'sd500, -24'sd500, -24'sd500, 23'd500, 1);
        feed(24'd40, 24'd40, 24'd40, 23'd500, 2);
        feed(-24'sd3, 24'd0, -24'sd2, 23'd500, 3);
        feed(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 23'h7FFFFF, 4);
        read_ready = 1'b1; stop = 1'b1;
        step;
        stop = 1'b0;
        checks++;
        if ({c_read, c_we, c_busy} !== 3'b000 || c_cnt !== 15'd5) begin
            errors++; $display("FAIL stop_on_pop: got read/we/busy %0b count %0d expected 000 5", {c_read, c_we, c_busy}, c_cnt);
        end
        step;
        checks++;
        if (c_read !== 1'b0) begin
            errors++; $display("FAIL stop_idle_read: got %0b expected 0", c_read);
        end
        read_ready = 1'b0;
        start = 1'b1; step; start = 1'b0;
        checks++;
        if (c_cnt !== 15'd0 || c_peak !== 23'd0) begin
            errors++; $display("FAIL start_clear: got count %0d peak %0h expected 0 0", c_cnt, c_peak);
        end
        feed(24'h800000, 24'h800000, 24'h800000, 23'h7FFFFF, 0);
    endtask

    initial begin
        test_reset;
        test_record_basic;
        test_skip;
        test_data_peak_stop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
